// File: rtl/desc_slot_scheduler_if.sv
// Descriptor handshake bundle between the ingress FIFO, the scheduler and the per-core interconnect.
// The scheduler uses the slave view; the ingress/egress environment uses the master view.
interface desc_slot_scheduler_if #(
    parameter int DESC_WIDTH    = 64,
    parameter int CORE_ID_WIDTH = 3
);
    logic [DESC_WIDTH-1:0]    s_desc;
    logic                     s_desc_valid;
    logic                     s_desc_ready;
    logic [DESC_WIDTH-1:0]    m_desc;
    logic [CORE_ID_WIDTH-1:0] m_desc_core;
    logic                     m_desc_valid;
    logic                     m_desc_ready;

    modport master (
        output s_desc, s_desc_valid, m_desc_ready,
        input  s_desc_ready, m_desc, m_desc_core, m_desc_valid
    );

    modport slave (
        input  s_desc, s_desc_valid, m_desc_ready,
        output s_desc_ready, m_desc, m_desc_core, m_desc_valid
    );
endinterface

// File: rtl/desc_slot_scheduler.sv
// Round-robin descriptor dispatcher to CORE_COUNT cores with per-core slot-credit accounting.
// One-entry output register (EMPTY/FULL) supports one dispatch per cycle under continuous ready.
module desc_slot_scheduler #(
    parameter int CORE_COUNT    = 8,
    parameter int CORE_ID_WIDTH = 3,
    parameter int SLOT_COUNT    = 16,
    parameter int DESC_WIDTH    = 64,
    parameter int CREDIT_WIDTH  = $clog2(SLOT_COUNT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    desc_slot_scheduler_if.slave     bus,
    input  logic                     slot_done_valid,
    input  logic [CORE_ID_WIDTH-1:0] slot_done_core,
    input  logic [CORE_COUNT-1:0]    core_enable,
    input  logic [CORE_COUNT-1:0]    core_flush,
    input  logic [CORE_ID_WIDTH-1:0] stat_core_sel,
    output logic [CREDIT_WIDTH-1:0]  stat_credit,
    output logic                     err_sticky
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0]  CREDIT_FULL = CREDIT_WIDTH'(SLOT_COUNT);
    localparam logic [CORE_ID_WIDTH-1:0] RR_INIT     = CORE_ID_WIDTH'(CORE_COUNT - 1);

    state_t                   state_q, state_d;
    logic [CREDIT_WIDTH-1:0]  credit_q [CORE_COUNT];
    logic [CREDIT_WIDTH-1:0]  credit_d [CORE_COUNT];
    logic [CORE_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [DESC_WIDTH-1:0]    m_desc_q, m_desc_d;
    logic [CORE_ID_WIDTH-1:0] m_core_q, m_core_d;
    logic [CREDIT_WIDTH-1:0]  stat_q, stat_d;
    logic                     err_q, err_d;

    logic [CORE_COUNT-1:0]    elig;
    logic [CORE_COUNT-1:0]    done_hit;
    logic [CORE_COUNT-1:0]    acc_hit;
    logic [CORE_ID_WIDTH-1:0] sel;
    logic                     any_elig;
    logic                     accept;

    // Eligibility looks only at registered credit, so a slot returned this cycle counts next cycle.
    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            elig[i] = core_enable[i] && (credit_q[i] != '0) && !core_flush[i];
        end
    end

    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        for (int k = 1; k <= CORE_COUNT; k++) begin
            for (int j = 0; j < CORE_COUNT; j++) begin
                if (!any_elig && elig[j] && (j == (int'(rr_ptr_q) + k) % CORE_COUNT)) begin
                    any_elig = 1'b1;
                    sel      = CORE_ID_WIDTH'(j);
                end
            end
        end
    end

    assign bus.s_desc_ready = rst_n && any_elig && ((state_q == ST_EMPTY) || bus.m_desc_ready);
    assign accept           = bus.s_desc_valid && bus.s_desc_ready;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        m_desc_d = m_desc_q;
        m_core_d = m_core_q;
        if (accept) begin
            m_desc_d = bus.s_desc;
            m_core_d = sel;
            rr_ptr_d = sel;
        end
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (bus.m_desc_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Flush beats everything; a matched accept+done cancels out; overflow saturates and flags.
    always_comb begin
        err_d = err_q;
        if (slot_done_valid && (int'(slot_done_core) >= CORE_COUNT)) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < CORE_COUNT; i++) begin
            done_hit[i] = slot_done_valid && (slot_done_core == CORE_ID_WIDTH'(i));
            acc_hit[i]  = accept && (sel == CORE_ID_WIDTH'(i));
            credit_d[i] = credit_q[i];
            if (core_flush[i]) begin
                credit_d[i] = CREDIT_FULL;
            end else if (done_hit[i] && acc_hit[i]) begin
                credit_d[i] = credit_q[i];
            end else if (done_hit[i]) begin
                if (credit_q[i] == CREDIT_FULL) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CREDIT_WIDTH'(1);
                end
            end else if (acc_hit[i]) begin
                credit_d[i] = credit_q[i] - CREDIT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        stat_d = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (stat_core_sel == CORE_ID_WIDTH'(i)) stat_d = credit_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            rr_ptr_q <= RR_INIT;
            m_desc_q <= '0;
            m_core_q <= '0;
            stat_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < CORE_COUNT; i++) credit_q[i] <= CREDIT_FULL;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            m_desc_q <= m_desc_d;
            m_core_q <= m_core_d;
            stat_q   <= stat_d;
            err_q    <= err_d;
            for (int i = 0; i < CORE_COUNT; i++) credit_q[i] <= credit_d[i];
        end
    end

    assign bus.m_desc       = m_desc_q;
    assign bus.m_desc_core  = m_core_q;
    assign bus.m_desc_valid = (state_q == ST_FULL);
    assign stat_credit      = stat_q;
    assign err_sticky       = err_q;

endmodule

// File: tb/tb_desc_slot_scheduler.sv
// Directed bench for desc_slot_scheduler: an 8-core instance for dispatch/credit scenarios and a
// 6-core instance for out-of-range slot returns.
module tb_desc_slot_scheduler;

    logic clk;
    logic rst_n;

    logic       slot_done_valid, slot_done_valid6;
    logic [2:0] slot_done_core, slot_done_core6;
    logic [7:0] core_enable, core_flush;
    logic [5:0] core_enable6, core_flush6;
    logic [2:0] stat_core_sel, stat_core_sel6;
    logic [4:0] stat_credit, stat_credit6;
    logic       err_sticky, err_sticky6;

    int n_checks;
    int n_pass;

    desc_slot_scheduler_if #(.DESC_WIDTH(64), .CORE_ID_WIDTH(3)) bus8 ();
    desc_slot_scheduler_if #(.DESC_WIDTH(64), .CORE_ID_WIDTH(3)) bus6 ();

    desc_slot_scheduler #(
        .CORE_COUNT(8), .CORE_ID_WIDTH(3), .SLOT_COUNT(16), .DESC_WIDTH(64)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus8),
        .slot_done_valid(slot_done_valid), .slot_done_core(slot_done_core),
        .core_enable(core_enable), .core_flush(core_flush),
        .stat_core_sel(stat_core_sel), .stat_credit(stat_credit), .err_sticky(err_sticky)
    );

    desc_slot_scheduler #(
        .CORE_COUNT(6), .CORE_ID_WIDTH(3), .SLOT_COUNT(16), .DESC_WIDTH(64)
    ) u_dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6),
        .slot_done_valid(slot_done_valid6), .slot_done_core(slot_done_core6),
        .core_enable(core_enable6), .core_flush(core_flush6),
        .stat_core_sel(stat_core_sel6), .stat_credit(stat_credit6), .err_sticky(err_sticky6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_all();
        core_flush = 8'hFF;
        step();
        core_flush = 8'h00;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus8.s_desc_ready !== 1'b0) $display("FAIL rst_ready_low: got %b want 0", bus8.s_desc_ready); else n_pass++;
        n_checks++; if (bus8.m_desc_valid !== 1'b0) $display("FAIL rst_valid_low: got %b want 0", bus8.m_desc_valid); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_checks++; if (stat_credit !== 5'd0) $display("FAIL rst_stat: got %0d want 0", stat_credit); else n_pass++;
        n_checks++; if (err_sticky !== 1'b0) $display("FAIL rst_err: got %b want 0", err_sticky); else n_pass++;
        n_checks++; if (bus8.m_desc_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus8.m_desc_valid); else n_pass++;
        n_checks++; if (bus8.m_desc_core !== 3'd0) $display("FAIL rst_core: got %0d want 0", bus8.m_desc_core); else n_pass++;
        n_checks++; if (bus8.m_desc !== 64'd0) $display("FAIL rst_desc: got %0h want 0", bus8.m_desc); else n_pass++;
        n_checks++; if (bus8.s_desc_ready !== 1'b1) $display("FAIL rst_ready_idle: got %b want 1", bus8.s_desc_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus8.m_desc_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus8.s_desc_valid = 1'b1;
            bus8.s_desc       = 64'h100 + 64'(k);
            #1;
            n_checks++; if (bus8.s_desc_ready !== 1'b1) $display("FAIL b2b_ready k=%0d: got %b want 1", k, bus8.s_desc_ready); else n_pass++;
            step();
            n_checks++; if (bus8.m_desc_valid !== 1'b1) $display("FAIL b2b_valid k=%0d: got %b want 1", k, bus8.m_desc_valid); else n_pass++;
            n_checks++; if (bus8.m_desc_core !== 3'(k)) $display("FAIL b2b_core k=%0d: got %0d want %0d", k, bus8.m_desc_core, k); else n_pass++;
            n_checks++; if (bus8.m_desc !== 64'h100 + 64'(k)) $display("FAIL b2b_desc k=%0d: got %0h want %0h", k, bus8.m_desc, 64'h100 + 64'(k)); else n_pass++;
        end
        bus8.s_desc_valid = 1'b0;
        step();
        n_checks++; if (bus8.m_desc_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", bus8.m_desc_valid); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            stat_core_sel = 3'(j);
            step();
            n_checks++; if (stat_credit !== 5'd15) $display("FAIL b2b_credit core=%0d: got %0d want 15", j, stat_credit); else n_pass++;
        end
    endtask

    task automatic test_single_core();
        flush_all();
        core_enable       = 8'h04;
        bus8.m_desc_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus8.s_desc_valid = 1'b1;
            bus8.s_desc       = 64'h200 + 64'(k);
            #1;
            n_checks++; if (bus8.s_desc_ready !== 1'b1) $display("FAIL one_ready k=%0d: got %b want 1", k, bus8.s_desc_ready); else n_pass++;
            step();
            n_checks++; if (bus8.m_desc_core !== 3'd2) $display("FAIL one_core k=%0d: got %0d want 2", k, bus8.m_desc_core); else n_pass++;
        end
        bus8.s_desc = 64'h210;
        #1;
        n_checks++; if (bus8.s_desc_ready !== 1'b0) $display("FAIL one_nocredit: got %b want 0", bus8.s_desc_ready); else n_pass++;
        stat_core_sel = 3'd2;
        step();
        n_checks++; if (bus8.m_desc_valid !== 1'b0) $display("FAIL one_drain: got %b want 0", bus8.m_desc_valid); else n_pass++;
        step();
        n_checks++; if (stat_credit !== 5'd0) $display("FAIL one_credit0: got %0d want 0", stat_credit); else n_pass++;
        slot_done_valid = 1'b1;
        slot_done_core  = 3'd2;
        #1;
        n_checks++; if (bus8.s_desc_ready !== 1'b0) $display("FAIL one_same_cycle_done: got %b want 0", bus8.s_desc_ready); else n_pass++;
        step();
        slot_done_valid = 1'b0;
        #1;
        n_checks++; if (bus8.s_desc_ready !== 1'b1) $display("FAIL one_ready_after_done: got %b want 1", bus8.s_desc_ready); else n_pass++;
        step();
        bus8.s_desc_valid = 1'b0;
        n_checks++; if (bus8.m_desc_valid !== 1'b1) $display("FAIL one_17_valid: got %b want 1", bus8.m_desc_valid); else n_pass++;
        n_checks++; if (bus8.m_desc !== 64'h210) $display("FAIL one_17_desc: got %0h want 210", bus8.m_desc); else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        flush_all();
        core_enable       = 8'hFF;
        bus8.m_desc_ready = 1'b0;
        bus8.s_desc_valid = 1'b1;
        bus8.s_desc       = 64'h300;
        stat_core_sel     = 3'd3;
        #1;
        n_checks++; if (bus8.s_desc_ready !== 1'b1) $display("FAIL bp_ready_empty: got %b want 1", bus8.s_desc_ready); else n_pass++;
        step();
        n_checks++; if (bus8.m_desc_core !== 3'd3) $display("FAIL bp_first_core: got %0d want 3", bus8.m_desc_core); else n_pass++;
        bus8.s_desc = 64'h301;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (bus8.s_desc_ready !== 1'b0) $display("FAIL bp_ready c=%0d: got %b want 0", c, bus8.s_desc_ready); else n_pass++;
            step();
            n_checks++; if (bus8.m_desc_valid !== 1'b1 || bus8.m_desc !== 64'h300 || bus8.m_desc_core !== 3'd3)
                $display("FAIL bp_hold c=%0d: got v=%b d=%0h core=%0d want v=1 d=300 core=3", c, bus8.m_desc_valid, bus8.m_desc, bus8.m_desc_core);
            else n_pass++;
        end
        n_checks++; if (stat_credit !== 5'd15) $display("FAIL bp_credit: got %0d want 15", stat_credit); else n_pass++;
        bus8.m_desc_ready = 1'b1;
        #1;
        n_checks++; if (bus8.s_desc_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus8.s_desc_ready); else n_pass++;
        step();
        bus8.s_desc_valid = 1'b0;
        n_checks++; if (bus8.m_desc !== 64'h301 || bus8.m_desc_core !== 3'd4)
            $display("FAIL bp_next: got d=%0h core=%0d want d=301 core=4", bus8.m_desc, bus8.m_desc_core);
        else n_pass++;
        step();
        n_checks++; if (bus8.m_desc_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus8.m_desc_valid); else n_pass++;
    endtask

    task automatic test_same_cycle();
        flush_all();
        core_enable       = 8'h08;
        bus8.m_desc_ready = 1'b1;
        stat_core_sel     = 3'd3;
        for (int k = 0; k < 12; k++) begin
            bus8.s_desc_valid = 1'b1;
            bus8.s_desc       = 64'h400 + 64'(k);
            step();
        end
        bus8.s_desc_valid = 1'b0;
        step();
        step();
        n_checks++; if (stat_credit !== 5'd4) $display("FAIL sc_credit4: got %0d want 4", stat_credit); else n_pass++;
        bus8.s_desc_valid = 1'b1;
        slot_done_valid   = 1'b1;
        slot_done_core    = 3'd3;
        #1;
        n_checks++; if (bus8.s_desc_ready !== 1'b1) $display("FAIL sc_ready: got %b want 1", bus8.s_desc_ready); else n_pass++;
        step();
        bus8.s_desc_valid = 1'b0;
        slot_done_valid   = 1'b0;
        step();
        step();
        n_checks++; if (stat_credit !== 5'd4) $display("FAIL sc_acc_done: got %0d want 4", stat_credit); else n_pass++;
        core_flush      = 8'h08;
        slot_done_valid = 1'b1;
        slot_done_core  = 3'd3;
        step();
        core_flush      = 8'h00;
        slot_done_valid = 1'b0;
        step();
        n_checks++; if (stat_credit !== 5'd16) $display("FAIL sc_flush_credit: got %0d want 16", stat_credit); else n_pass++;
        n_checks++; if (err_sticky !== 1'b0) $display("FAIL sc_flush_err: got %b want 0", err_sticky); else n_pass++;
    endtask

    task automatic test_overflow();
        stat_core_sel   = 3'd0;
        slot_done_valid = 1'b1;
        slot_done_core  = 3'd0;
        step();
        slot_done_valid = 1'b0;
        step();
        n_checks++; if (stat_credit !== 5'd16) $display("FAIL ovf_credit: got %0d want 16", stat_credit); else n_pass++;
        n_checks++; if (err_sticky !== 1'b1) $display("FAIL ovf_err: got %b want 1", err_sticky); else n_pass++;
        n_checks++; if (err_sticky6 !== 1'b0) $display("FAIL oor_err_before: got %b want 0", err_sticky6); else n_pass++;
        stat_core_sel6   = 3'd7;
        slot_done_valid6 = 1'b1;
        slot_done_core6  = 3'd7;
        step();
        slot_done_valid6 = 1'b0;
        step();
        n_checks++; if (err_sticky6 !== 1'b1) $display("FAIL oor_err: got %b want 1", err_sticky6); else n_pass++;
        n_checks++; if (stat_credit6 !== 5'd0) $display("FAIL oor_stat_sel: got %0d want 0", stat_credit6); else n_pass++;
        for (int j = 0; j < 6; j++) begin
            stat_core_sel6 = 3'(j);
            step();
            n_checks++; if (stat_credit6 !== 5'd16) $display("FAIL oor_credit core=%0d: got %0d want 16", j, stat_credit6); else n_pass++;
        end
    endtask

    task automatic test_reset_midop();
        core_enable       = 8'hFF;
        bus8.m_desc_ready = 1'b0;
        bus8.s_desc_valid = 1'b1;
        bus8.s_desc       = 64'h500;
        step();
        bus8.s_desc_valid = 1'b0;
        n_checks++; if (bus8.m_desc_valid !== 1'b1 || bus8.m_desc_core !== 3'd4)
            $display("FAIL mid_full: got v=%b core=%0d want v=1 core=4", bus8.m_desc_valid, bus8.m_desc_core);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus8.m_desc_valid !== 1'b0) $display("FAIL mid_async_valid: got %b want 0", bus8.m_desc_valid); else n_pass++;
        n_checks++; if (bus8.s_desc_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", bus8.s_desc_ready); else n_pass++;
        n_checks++; if (err_sticky !== 1'b0) $display("FAIL mid_err_clear: got %b want 0", err_sticky); else n_pass++;
        n_checks++; if (bus8.m_desc !== 64'd0) $display("FAIL mid_desc_clear: got %0h want 0", bus8.m_desc); else n_pass++;
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            stat_core_sel = 3'(j);
            step();
            n_checks++; if (stat_credit !== 5'd16) $display("FAIL mid_credit core=%0d: got %0d want 16", j, stat_credit); else n_pass++;
        end
        bus8.m_desc_ready = 1'b1;
        bus8.s_desc_valid = 1'b1;
        bus8.s_desc       = 64'h600;
        step();
        bus8.s_desc_valid = 1'b0;
        n_checks++; if (bus8.m_desc_core !== 3'd0 || bus8.m_desc !== 64'h600)
            $display("FAIL mid_first_core: got core=%0d d=%0h want core=0 d=600", bus8.m_desc_core, bus8.m_desc);
        else n_pass++;
        step();
    endtask

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        rst_n             = 1'b0;
        bus8.s_desc       = '0;
        bus8.s_desc_valid = 1'b0;
        bus8.m_desc_ready = 1'b0;
        bus6.s_desc       = '0;
        bus6.s_desc_valid = 1'b0;
        bus6.m_desc_ready = 1'b0;
        slot_done_valid   = 1'b0;
        slot_done_core    = '0;
        slot_done_valid6  = 1'b0;
        slot_done_core6   = '0;
        core_enable       = 8'hFF;
        core_flush        = 8'h00;
        core_enable6      = 6'h00;
        core_flush6       = 6'h00;
        stat_core_sel     = '0;
        stat_core_sel6    = '0;

        test_reset();
        test_back_to_back();
        test_single_core();
        test_backpressure();
        test_same_cycle();
        test_overflow();
        test_reset_midop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/desc_slot_scheduler.md
Name: desc_slot_scheduler

Overview:
- Distributes incoming packet descriptors from the ingress path to CORE_COUNT Gousheh_PR cores.
- Keeps one slot-credit counter per core: a counter decrements when a descriptor is dispatched to that core and increments when the core returns a slot.
- Chooses the target core by round-robin over enabled cores that have credit.
- Sits between the ingress descriptor FIFO and the per-core in_desc interconnect.

Parameters:
CORE_COUNT, 8, number of cores scheduled
CORE_ID_WIDTH, 3, width of core index; must satisfy 2**CORE_ID_WIDTH >= CORE_COUNT
SLOT_COUNT, 16, slots per core; reset and flush value of each credit counter
DESC_WIDTH, 64, descriptor width
CREDIT_WIDTH, $clog2(SLOT_COUNT+1), width of each credit counter

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s_desc  in  DESC_WIDTH  incoming descriptor
s_desc_valid  in  1  incoming descriptor valid
s_desc_ready  out  1  incoming descriptor accepted
m_desc  out  DESC_WIDTH  dispatched descriptor
m_desc_core  out  CORE_ID_WIDTH  target core of m_desc
m_desc_valid  out  1  dispatch valid
m_desc_ready  in  1  downstream accepts dispatch
slot_done_valid  in  1  one slot returned (single-cycle pulse)
slot_done_core  in  CORE_ID_WIDTH  core returning the slot
core_enable  in  CORE_COUNT  per-core scheduling enable (level)
core_flush  in  CORE_COUNT  per-core pulse: restore credit to SLOT_COUNT (issued after core_reset)
stat_core_sel  in  CORE_ID_WIDTH  credit readout select
stat_credit  out  CREDIT_WIDTH  registered credit of stat_core_sel, 1-cycle latency
err_sticky  out  1  sticky error flag; cleared only by rst_n

Behaviour:
- Reset (async assert, sync release):
  - credit[i]=SLOT_COUNT; rr_ptr=CORE_COUNT-1.
  - m_desc_valid=0, m_desc=0, m_desc_core=0.
  - stat_credit=0, err_sticky=0, FSM=EMPTY.
  - s_desc_ready=0 while rst_n is low.
- Eligibility: elig[i] = core_enable[i] && credit[i]!=0 && !core_flush[i].
  - Uses registered credit only; a same-cycle slot_done does not create eligibility.
- Selection: first eligible core searching from rr_ptr+1 upward, wrapping modulo CORE_COUNT. The search is combinational.
- s_desc_ready = |elig && (FSM==EMPTY || m_desc_ready). It must not depend on s_desc_valid.
- Accept (s_desc_valid && s_desc_ready):
  - m_desc<=s_desc; m_desc_core<=sel; rr_ptr<=sel.
  - credit[sel] decrements; m_desc_valid<=1 on the next edge.
  - Latency: accept at edge N, m_desc_valid high after edge N.
- FSM:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on m_desc_ready without accept.
  - FULL -> FULL on m_desc_ready with accept (back-to-back, one descriptor per cycle).
  - FULL holds while !m_desc_ready; m_desc and m_desc_core are stable while valid && !ready.
- Credit update per core, in priority order:
  1. flush: credit=SLOT_COUNT; any same-cycle done for that core is ignored.
  2. accept to core and done for core in the same cycle: credit unchanged.
  3. done only: +1. If credit==SLOT_COUNT it saturates and sets err_sticky.
  4. accept only: -1. Never underflows, because accept requires credit!=0.
- slot_done_core >= CORE_COUNT with slot_done_valid: ignored, sets err_sticky.
- Clearing core_enable[i] removes core i from selection next cycle. A descriptor already held for core i is still presented until taken; credits keep counting.
- Reset mid-operation: a held descriptor is dropped, m_desc_valid deasserts asynchronously, all credits return to SLOT_COUNT.
- No eligible core: s_desc_ready=0; a held output still drains normally.
- stat_credit <= credit[stat_core_sel] each cycle; out-of-range select returns 0.

Test Plan:
- Reset, all 8 cores enabled, 8 back-to-back descriptors with m_desc_ready=1 -> m_desc_core = 0,1,...,7 on consecutive cycles, first m_desc_valid one cycle after first accept, each stat_credit=15.
- Enable only core 2, send 17 descriptors, no slot_done -> 16 dispatched to core 2, s_desc_ready=0 afterwards. One slot_done for core 2 -> 17th accepted the following cycle.
- Hold m_desc_ready=0 for 5 cycles with descriptor pending -> m_desc and m_desc_core stable, s_desc_ready=0, no credit change. Release -> dispatch plus next accept in same cycle.
- Core 3 credit=4: same-cycle accept to core 3 and slot_done for core 3 -> credit stays 4. core_flush[3] with same-cycle done -> credit=16, err_sticky=0.
- slot_done for core 0 at credit 16 -> credit stays 16, err_sticky=1. slot_done_core=7 with CORE_COUNT=6 -> err_sticky=1, credits unchanged.
- Assert rst_n low while FULL with credits reduced -> m_desc_valid=0 immediately, all credits 16 after release, next dispatch targets core 0.
